// File: rtl/rotate_arbiter_2ch.sv
// rotate_arbiter_2ch
// Two-requester round-robin front end for a shared 16-bit right rotator.
// Accepts at most one job per cycle from two valid/ready ports, rotates the
// granted operand and registers the result into a single-entry output stage
// tagged with the requester ID.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   req0_valid / req0_ready    : channel 0 handshake (ready is combinational)
//   req0_a, req0_amt           : channel 0 operand and rotate amount
//   req1_*                     : same for channel 1
//   out_valid / out_ready      : result handshake
//   out_y, out_id              : rotated result and issuing channel
//
// Optional feature: define ROTATE_LEFT_EN to add req0_dir / req1_dir.
// dir=1 requests a left rotate, implemented as a right rotate by (-amt) mod 16.
//
// state | meaning
// EMPTY | no result held, out_valid=0
// FULL  | result held in out_y/out_id, out_valid=1

module rotate_arbiter_2ch (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [3:0]  req0_amt,
`ifdef ROTATE_LEFT_EN
   input  logic        req0_dir,
`endif
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [3:0]  req1_amt,
`ifdef ROTATE_LEFT_EN
   input  logic        req1_dir,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_y,
   output logic        out_id
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        rr, rr_nxt;
   logic        can_accept;
   logic        grant0, grant1;
   logic [15:0] sel_a;
   logic [3:0]  sel_amt;
   logic [3:0]  rot_amt;
   logic [15:0] rot_y;
   logic [15:0] y_nxt;
   logic        id_nxt;

   // Grant and rotator operand selection
   always_comb begin
      can_accept = 1'b0;
      grant0     = 1'b0;
      grant1     = 1'b0;
      sel_a      = req0_a;
      sel_amt    = req0_amt;
      rot_amt    = req0_amt;
      rot_y      = 16'h0000;

      // Reset gates acceptance so a request held across reset is not acked.
      can_accept = !reset && ((state == EMPTY) || out_ready);
      grant0     = can_accept && req0_valid && (!req1_valid || (rr == 1'b0));
      grant1     = can_accept && req1_valid && (!req0_valid || (rr == 1'b1));

      if (grant1) begin
         sel_a   = req1_a;
         sel_amt = req1_amt;
      end

      rot_amt = sel_amt;
`ifdef ROTATE_LEFT_EN
      // Left rotate by amt equals right rotate by the 4-bit negation of amt.
      if ((grant1 && req1_dir) || (!grant1 && req0_dir))
         rot_amt = 4'd0 - sel_amt;
`endif
      // Shift by 16 on the left term yields zero, so amt=0 is a pass-through.
      rot_y = (sel_a >> rot_amt) | (sel_a << (5'd16 - {1'b0, rot_amt}));
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign out_valid  = (state == FULL);

   // Next state for the output stage and round-robin pointer
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      y_nxt     = out_y;
      id_nxt    = out_id;

      if (grant0 || grant1) begin
         state_nxt = FULL;
         y_nxt     = rot_y;
         id_nxt    = grant1;
         rr_nxt    = grant0;   // pointer moves to the channel that lost
      end else if ((state == FULL) && out_ready) begin
         state_nxt = EMPTY;    // drain only; y/id hold their last value
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         rr     <= 1'b0;
         out_y  <= 16'h0000;
         out_id <= 1'b0;
      end else begin
         state  <= state_nxt;
         rr     <= rr_nxt;
         out_y  <= y_nxt;
         out_id <= id_nxt;
      end
   end

endmodule
